// File: rtl/spi_rdid_slave.sv
// rtl/spi_rdid_slave.sv - SPI mode-0 flash stand-in answering the RDID (JEDEC ID) instruction
module spi_rdid_slave #(
    parameter logic [7:0] RDID_OPCODE     = 8'h9F,
    parameter logic [7:0] MANUFACTURER_ID = 8'h20,
    parameter logic [7:0] MEMORY_TYPE     = 8'h20,
    parameter logic [7:0] MEMORY_CAPACITY = 8'h17,
    parameter int         COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               SPICLK,
    input  logic               chip_select,
    input  logic               SPIMOSI,
    output logic               SPIMISO,
    output logic               cmd_valid,
    output logic [7:0]         cmd_byte,
    output logic               rdid_done,
    output logic [COUNT_W-1:0] rdid_count
);

    localparam logic [23:0] ID_WORD = {MANUFACTURER_ID, MEMORY_TYPE, MEMORY_CAPACITY};

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_SEND, S_IGNORE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sclk_meta, r_sclk_sync, r_sclk_hist;
    logic               r_cs_meta, r_cs_sync, r_cs_hist;
    logic               r_mosi_meta, r_mosi_sync, r_mosi_hist;
    logic [2:0]         r_live;
    logic [6:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [4:0]         r_data_cnt;
    logic [4:0]         r_bit_idx;
    logic               r_id_done;
    logic               r_miso;
    logic               r_cmd_valid;
    logic [7:0]         r_cmd_byte;
    logic               r_rdid_done;
    logic [COUNT_W-1:0] r_count;

    logic               w_live;
    logic               w_rise, w_fall, w_cs_fall, w_cs_rise;
    logic [7:0]         w_instr;
    logic               w_in_cmd, w_in_send, w_last_instr, w_opcode_hit, w_miso_bit;

    // r_live marks when the history flop holds a real pin sample, so a select
    // already low at reset release never looks like a fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_meta <= 1'b0; r_sclk_sync <= 1'b0; r_sclk_hist <= 1'b0;
            r_cs_meta   <= 1'b1; r_cs_sync   <= 1'b1; r_cs_hist   <= 1'b1;
            r_mosi_meta <= 1'b0; r_mosi_sync <= 1'b0; r_mosi_hist <= 1'b0;
            r_live      <= 3'b000;
        end else begin
            r_sclk_meta <= SPICLK;      r_sclk_sync <= r_sclk_meta; r_sclk_hist <= r_sclk_sync;
            r_cs_meta   <= chip_select; r_cs_sync   <= r_cs_meta;   r_cs_hist   <= r_cs_sync;
            r_mosi_meta <= SPIMOSI;     r_mosi_sync <= r_mosi_meta; r_mosi_hist <= r_mosi_sync;
            r_live      <= {r_live[1:0], 1'b1};
        end
    end

    // SPICLK edges count only while selected; a deselect in the same cycle wins.
    assign w_live    = r_live[2];
    assign w_rise    = w_live &  r_sclk_sync & ~r_sclk_hist & ~r_cs_sync;
    assign w_fall    = w_live & ~r_sclk_sync &  r_sclk_hist & ~r_cs_sync;
    assign w_cs_fall = w_live & ~r_cs_sync   &  r_cs_hist;
    assign w_cs_rise = w_live &  r_cs_sync   & ~r_cs_hist;
    assign w_instr   = {r_shift, r_mosi_sync};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_cs_fall) w_state_next = S_CMD;
                S_CMD:    if (w_rise && r_bit_cnt == 3'd7)
                              w_state_next = (w_instr == RDID_OPCODE) ? S_SEND : S_IGNORE;
                default:  w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_in_cmd     = (r_state == S_CMD);
        w_in_send    = (r_state == S_SEND) && !w_cs_rise;
        w_last_instr = w_in_cmd && w_rise && (r_bit_cnt == 3'd7);
        w_opcode_hit = w_last_instr && (w_instr == RDID_OPCODE);
        w_miso_bit   = ID_WORD[r_bit_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_data_cnt  <= '0;
            r_bit_idx   <= '0;
            r_id_done   <= 1'b0;
            r_miso      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_byte  <= '0;
            r_rdid_done <= 1'b0;
            r_count     <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_rdid_done <= 1'b0;
            if (r_state == S_IDLE && w_cs_fall) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end
            if (w_in_cmd && w_rise) begin
                r_shift   <= w_instr[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_last_instr) begin
                r_cmd_byte  <= w_instr;
                r_cmd_valid <= 1'b1;
            end
            if (w_opcode_hit) begin
                r_data_cnt <= 5'd23;
                r_bit_idx  <= 5'd23;
                r_id_done  <= 1'b0;
            end
            // rdid_done fires once per select; later rises keep the ID cycling silently.
            if (w_in_send && w_rise && !r_id_done) begin
                if (r_data_cnt == 5'd0) begin
                    r_rdid_done <= 1'b1;
                    r_count     <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
                    r_id_done   <= 1'b1;
                end else begin
                    r_data_cnt <= r_data_cnt - 5'd1;
                end
            end
            if (w_in_send && w_fall) begin
                r_miso    <= w_miso_bit;
                r_bit_idx <= (r_bit_idx == 5'd0) ? 5'd23 : r_bit_idx - 5'd1;
            end else if (!w_in_send) begin
                r_miso <= 1'b0;
            end
        end
    end

    assign SPIMISO    = r_miso;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_byte   = r_cmd_byte;
    assign rdid_done  = r_rdid_done;
    assign rdid_count = r_count;

endmodule

// File: tb/tb_spi_rdid_slave.sv
// tb/tb_spi_rdid_slave.sv - randomized SPI master driving two RDID slaves against a transaction-level model
module tb_spi_rdid_slave;

    localparam logic [23:0] ID_A = 24'h202017;
    localparam logic [23:0] ID_B = 24'hEF4018;

    logic       clk = 1'b0;
    logic       reset, sclk, cs_n, mosi;
    logic       miso_a, miso_b, cv_a, cv_b, done_a, done_b;
    logic [7:0] cb_a, cb_b, cnt_a, cnt_b;

    int         n_vec = 0;
    int         n_err = 0;
    int         exp_count = 0;
    logic [7:0] exp_cmd = 8'h00;
    bit         settled = 1'b0;
    bit         miso_zero = 1'b1;
    int         hmax = 5;
    int         p_cv_a, p_cv_b, p_done_a, p_done_b;
    logic [23:0] got_a, got_b;

    always #5 clk = ~clk;

    spi_rdid_slave dut_a (
        .clk(clk), .reset(reset), .SPICLK(sclk), .chip_select(cs_n), .SPIMOSI(mosi),
        .SPIMISO(miso_a), .cmd_valid(cv_a), .cmd_byte(cb_a), .rdid_done(done_a), .rdid_count(cnt_a)
    );

    spi_rdid_slave #(.MANUFACTURER_ID(8'hEF), .MEMORY_TYPE(8'h40), .MEMORY_CAPACITY(8'h18)) dut_b (
        .clk(clk), .reset(reset), .SPICLK(sclk), .chip_select(cs_n), .SPIMOSI(mosi),
        .SPIMISO(miso_b), .cmd_valid(cv_b), .cmd_byte(cb_b), .rdid_done(done_b), .rdid_count(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of the slowly changing outputs plus pulse counting.
    always @(negedge clk) begin
        if (cv_a === 1'b1)   p_cv_a++;
        if (cv_b === 1'b1)   p_cv_b++;
        if (done_a === 1'b1) p_done_a++;
        if (done_b === 1'b1) p_done_b++;
        if (settled) begin
            check("rdid_count_a", {24'd0, cnt_a}, exp_count % 256);
            check("rdid_count_b", {24'd0, cnt_b}, exp_count % 256);
            check("cmd_byte_a", {24'd0, cb_a}, {24'd0, exp_cmd});
            check("cmd_byte_b", {24'd0, cb_b}, {24'd0, exp_cmd});
            if (miso_zero) begin
                check("miso_idle_a", {31'd0, miso_a}, 32'd0);
                check("miso_idle_b", {31'd0, miso_b}, 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic half();
        tick($urandom_range(hmax, 3));
    endtask

    task automatic clear_pulses();
        p_cv_a = 0; p_cv_b = 0; p_done_a = 0; p_done_b = 0;
    endtask

    // One select: ninstr instruction bits of op, then ndata clocks; keep_sel leaves CS low.
    task automatic spi_xfer(input logic [7:0] op, input int ninstr, input int ndata, input bit keep_sel);
        bit rdid;
        rdid = (ninstr == 8) && (op == 8'h9F);
        clear_pulses();
        cs_n = 1'b0;
        half();
        for (int i = 0; i < ninstr; i++) begin
            mosi = op[7-i];
            half();
            if (i == 7) settled = 1'b0;
            sclk = 1'b1;
            half();
            if (i == 7) begin
                exp_cmd = op;
                settled = 1'b1;
                if (rdid) miso_zero = 1'b0;
            end
            sclk = 1'b0;
        end
        for (int k = 0; k < ndata; k++) begin
            mosi = 1'($urandom);
            half();
            check("miso_bit_a", {31'd0, miso_a}, rdid ? {31'd0, ID_A[23 - (k % 24)]} : 32'd0);
            check("miso_bit_b", {31'd0, miso_b}, rdid ? {31'd0, ID_B[23 - (k % 24)]} : 32'd0);
            if (k < 24) begin
                got_a[23-k] = miso_a;
                got_b[23-k] = miso_b;
            end
            if (rdid && k == 23) settled = 1'b0;
            sclk = 1'b1;
            half();
            if (rdid && k == 23) begin
                exp_count++;
                settled = 1'b1;
            end
            sclk = 1'b0;
        end
        if (!keep_sel) begin
            half();
            cs_n = 1'b1;
            half();
            miso_zero = 1'b1;
            check("cmd_valid_pulses_a", p_cv_a, (ninstr == 8) ? 1 : 0);
            check("cmd_valid_pulses_b", p_cv_b, (ninstr == 8) ? 1 : 0);
            check("rdid_done_pulses_a", p_done_a, (rdid && ndata >= 24) ? 1 : 0);
            check("rdid_done_pulses_b", p_done_b, (rdid && ndata >= 24) ? 1 : 0);
            half();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, {30'd0, miso_a, miso_b}, 32'd0);
        check({tag, "_cmd_valid"}, {30'd0, cv_a, cv_b}, 32'd0);
        check({tag, "_rdid_done"}, {30'd0, done_a, done_b}, 32'd0);
        check({tag, "_cmd_byte"}, {16'd0, cb_a, cb_b}, 32'd0);
        check({tag, "_rdid_count"}, {16'd0, cnt_a, cnt_b}, 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        int         ni, nd;
        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(4);
        settled = 1'b1;

        // Directed: RDID with literal ID, ignored opcode, repeating ID, partial instruction.
        spi_xfer(8'h9F, 8, 24, 1'b0);
        check("first_id_a", {8'd0, got_a}, 32'h202017);
        check("first_id_b", {8'd0, got_b}, 32'hEF4018);
        check("first_count", {24'd0, cnt_a}, 32'd1);
        check("first_cmd", {24'd0, cb_a}, 32'h9F);
        spi_xfer(8'h05, 8, 24, 1'b0);
        check("ignored_cmd", {24'd0, cb_a}, 32'h05);
        spi_xfer(8'h9F, 8, 48, 1'b0);
        spi_xfer(8'h9F, 5, 0, 1'b0);
        spi_xfer(8'h9F, 8, 24, 1'b0);
        check("after_partial_count", {24'd0, cnt_a}, 32'd3);

        // Randomized transactions.
        for (int t = 0; t < 20; t++) begin
            op = ($urandom_range(2, 0) == 0) ? 8'($urandom) : 8'h9F;
            ni = ($urandom_range(5, 0) == 0) ? $urandom_range(7, 0) : 8;
            nd = (ni == 8) ? $urandom_range(40, 0) : 0;
            spi_xfer(op, ni, nd, 1'b0);
        end

        // Reset after 12 ID bits with the select still low.
        spi_xfer(8'h9F, 8, 12, 1'b1);
        settled = 1'b0;
        reset = 1'b1;
        tick(1);
        check_reset_outputs("midreset");
        reset = 1'b0;
        exp_count = 0;
        exp_cmd = 8'h00;
        miso_zero = 1'b1;
        tick(4);
        settled = 1'b1;
        clear_pulses();
        for (int i = 0; i < 8; i++) begin
            mosi = (i < 2) || (i > 2);
            half(); sclk = 1'b1; half(); sclk = 1'b0;
        end
        half();
        check("held_select_cmd_valid", p_cv_a + p_cv_b, 32'd0);
        cs_n = 1'b1;
        half(); half();
        spi_xfer(8'h9F, 8, 24, 1'b0);
        check("post_reset_id", {8'd0, got_a}, 32'h202017);
        check("post_reset_count", {24'd0, cnt_a}, 32'd1);

        // 256 back-to-back RDIDs wrap the 8-bit counter back to its start.
        hmax = 3;
        for (int t = 0; t < 256; t++) spi_xfer(8'h9F, 8, 24, 1'b0);
        check("wrap_count_a", {24'd0, cnt_a}, 32'd1);
        check("wrap_id_b", {8'd0, got_b}, 32'hEF4018);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_rdid_slave.md
Name: spi_rdid_slave

Overview:
- SPI mode-0 responder that models the serial-flash end of the RDID (JEDEC ID read) transaction.
- Oversamples SPICLK, chip_select and SPIMOSI in the system clock domain and captures the 8-bit instruction MSB-first.
- On opcode 0x9F, shifts the 24-bit ID (manufacturer, memory type, capacity) out on SPIMISO; other opcodes are reported and ignored.
- Serves as the on-board/bench counterpart for the SPI master and as a flash stand-in during bring-up.

Parameters:
- RDID_OPCODE, 8'h9F, instruction that triggers the ID response
- MANUFACTURER_ID, 8'h20, first byte shifted out (bits 23:16)
- MEMORY_TYPE, 8'h20, second byte (bits 15:8)
- MEMORY_CAPACITY, 8'h17, third byte (bits 7:0)
- COUNT_W, 8, width of the completed-RDID counter

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- SPICLK  input  1  serial clock from master; idles low (mode 0); asynchronous to clk
- chip_select  input  1  active-low slave select from master
- SPIMOSI  input  1  serial data from master, MSB first
- SPIMISO  output  1  serial data to master, MSB first
- cmd_valid  output  1  one-cycle pulse when the 8th instruction bit is captured
- cmd_byte  output  8  last captured instruction; held until next capture
- rdid_done  output  1  one-cycle pulse when all 24 ID bits have been sampled by the master
- rdid_count  output  COUNT_W  number of completed RDID transactions; wraps at 2^COUNT_W

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: SPIMISO=0, cmd_valid=0, cmd_byte=0, rdid_done=0, rdid_count=0, state=IDLE, bit counters=0, synchronizers=idle levels (SPICLK=0, chip_select=1, SPIMOSI=0).
- Synchronization and edge detection:
  - SPICLK, chip_select and SPIMOSI each pass through a 2-flop synchronizer plus one history flop.
  - Rise/fall are detected from synced vs history.
  - SPICLK high and low phases must each be >= 3 clk periods.
  - Pin-to-action latency is 3 clk cycles.
- Mode 0 timing:
  - SPIMOSI is sampled on the detected SPICLK rise.
  - SPIMISO is changed only on the detected SPICLK fall.
  - Latency from fall at the pin to SPIMISO update is <= 4 clk.
- State machine (state changes occur on SPICLK edges or chip_select edges):
  - IDLE: SPIMISO=0. A synced chip_select fall clears the 3-bit instruction counter and the shift register, then moves to CMD.
  - CMD: each SPICLK rise shifts SPIMOSI into the LSB. On the 8th rise, load cmd_byte and pulse cmd_valid next cycle. If the byte equals RDID_OPCODE, go to SEND with a 5-bit data counter of 23; otherwise go to IGNORE.
  - SEND:
    - The first SPICLK fall after entry drives MANUFACTURER_ID[7] (ID bit 23).
    - Each subsequent fall drives the next lower bit.
    - Each rise decrements the data counter.
    - On the rise that occurs at counter 0, pulse rdid_done and increment rdid_count.
    - After bit 0, the following falls restart at bit 23, so the ID repeats for as long as the master keeps clocking.
    - rdid_done pulses only for the first full 24 bits of a select.
  - IGNORE: SPIMISO=0, SPICLK edges are ignored.
- Any state: a synced chip_select rise returns to IDLE and forces SPIMISO=0 on the next cycle. A partial instruction is discarded (no cmd_valid); a partial ID gives no rdid_done.
- Edges while deselected: SPICLK edges with chip_select high are ignored.
- Reset mid-transaction: returns to IDLE immediately. rdid_count clears. The master must re-assert chip_select before a new command is recognised (a chip_select already low at reset release is not treated as a fall).
- Simultaneous chip_select rise and SPICLK edge in the same synced cycle: deselect wins, and the edge is ignored.

Test Plan:
- Reset, then master drives 0x9F followed by 24 clocks -> cmd_valid pulses once with cmd_byte=0x9F. MISO bits sampled on rises read 0x202017. rdid_done pulses once and rdid_count=1.
- Instruction 0x05 then 24 clocks -> cmd_byte=0x05, MISO held 0 throughout, no rdid_done, rdid_count unchanged.
- 0x9F then 48 clocks in one select -> master reads 0x202017 twice, rdid_done pulses exactly once.
- Deassert chip_select after 5 instruction bits, then a full 0x9F transaction -> no cmd_valid for the partial; the second transaction returns 0x202017 and rdid_count increments by 1.
- Assert reset after 12 ID bits -> all outputs return to reset values within 1 cycle. The next full transaction yields 0x202017 and rdid_count=1.
- 256 back-to-back RDID transactions with COUNT_W=8 -> rdid_count wraps to 0. Parameters overridden to 8'hEF/8'h40/8'h18 return 0xEF4018.
